// File: rtl/sparse_seq_pkg.sv
// Shared types and sizing for the sparse-data chunk sequencer.
// Holds the FSM state type, default geometry and a popcount helper.
package sparse_seq_pkg;

    localparam int MEM_SIZE_DEF  = 128;
    localparam int PSUM_SIZE_DEF = 32;
    localparam int WORDS         = MEM_SIZE_DEF / PSUM_SIZE_DEF;
    localparam int IDX_W         = $clog2(WORDS);
    localparam int BIT_W         = $clog2(PSUM_SIZE_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_WALK,
        ST_END,
        ST_DONE
    } seq_state_e;

    function automatic int unsigned popcount(input logic [PSUM_SIZE_DEF-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PSUM_SIZE_DEF; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/lsb_pri_enc.sv
// Combinational lowest-set-bit priority encoder.
// Also flags whether any bit is set and whether exactly one bit is set.
module lsb_pri_enc #(
    parameter  int WIDTH = 32,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [OUT_W-1:0] index_o,
    output logic             any_set_o,
    output logic             one_hot_single_o
);

    always_comb begin
        // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
        index_o = '0;
        // Scanning downward lets the lowest set bit make the final assignment.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                index_o = OUT_W'(i);
            end
        end
    end

    assign any_set_o        = |mask_i;
    assign one_hot_single_o = any_set_o && ((mask_i & (mask_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/sparse_chunk_seq.sv
// Chunk sequencer: fetches each sparsemap word, walks its set bits lowest-first
// and drives the read-address calculator alongside a valid/ready beat stream.
module sparse_chunk_seq
    import sparse_seq_pkg::*;
#(
    parameter  int MEM_SIZE        = MEM_SIZE_DEF,
    parameter  int PREFIX_SUM_SIZE = PSUM_SIZE_DEF,
    localparam int CHUNK_WORDS     = MEM_SIZE / PREFIX_SUM_SIZE,
    localparam int IDX_BITS        = $clog2(CHUNK_WORDS),
    localparam int POS_BITS        = $clog2(PREFIX_SUM_SIZE)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic                       smap_rd_en_o,
    output logic [IDX_BITS-1:0]        smap_rd_addr_o,
    input  logic [PREFIX_SUM_SIZE-1:0] smap_rd_dat_i,
    output logic [PREFIX_SUM_SIZE-1:0] sparsemap_o,
    output logic [POS_BITS-1:0]        pri_enc_match_addr_o,
    output logic                       pri_enc_end_o,
    output logic                       chunk_start_o,
    output logic                       req_valid_o,
    input  logic                       req_ready_i,
    output logic                       req_word_last_o,
    output logic                       busy_o,
    output logic                       done_o
);

    seq_state_e                 state_q, state_d;
    logic [IDX_BITS-1:0]        idx_q, idx_d;
    logic [PREFIX_SUM_SIZE-1:0] smap_q, smap_d;
    logic [PREFIX_SUM_SIZE-1:0] mask_q, mask_d;

    logic [POS_BITS-1:0] enc_idx;
    logic                enc_any;
    logic                enc_single;

    lsb_pri_enc #(
        .WIDTH (PREFIX_SUM_SIZE)
    ) u_pri_enc (
        .mask_i           (mask_q),
        .index_o          (enc_idx),
        .any_set_o        (enc_any),
        .one_hot_single_o (enc_single)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        smap_d  = smap_q;
        mask_d  = mask_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                smap_d  = smap_rd_dat_i;
                mask_d  = smap_rd_dat_i;
                state_d = (|smap_rd_dat_i) ? ST_WALK : ST_END;
            end
            ST_WALK: begin
                if (req_valid_o && req_ready_i) begin
                    mask_d = mask_q & (mask_q - PREFIX_SUM_SIZE'(1));
                    if (enc_single) begin
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (idx_q == IDX_BITS'(CHUNK_WORDS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_BITS'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over start and over a handshake; the word stays visible.
        if (abort_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            smap_q  <= '0;
            mask_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            smap_q  <= smap_d;
            mask_q  <= mask_d;
        end
    end

    assign smap_rd_en_o         = (state_q == ST_FETCH);
    assign smap_rd_addr_o       = idx_q;
    assign chunk_start_o        = (state_q == ST_FETCH) && (idx_q == '0);
    assign sparsemap_o          = smap_q;
    assign pri_enc_match_addr_o = enc_idx;
    assign req_valid_o          = (state_q == ST_WALK) && enc_any;
    assign req_word_last_o      = (state_q == ST_WALK) && enc_single;
    assign pri_enc_end_o        = (state_q == ST_END);
    assign done_o               = (state_q == ST_DONE);
    assign busy_o               = (state_q != ST_IDLE);

endmodule
